// File: rtl/lut3_if.sv
`default_nettype none
// ============================================================================
// lut3_if : select inputs, function output and configuration bus of lut3
// Rev 1.0 : initial release
// ============================================================================
interface lut3_if;
  logic       A;
  logic       B;
  logic       C;
  logic       F;
  logic       cfg_we;
  logic [7:0] cfg_data;
  logic       cfg_bit_we;
  logic [2:0] cfg_addr;
  logic       cfg_bit;
  logic [7:0] cfg_table;

  modport master (
    output A, B, C, cfg_we, cfg_data, cfg_bit_we, cfg_addr, cfg_bit,
    input  F, cfg_table
  );

  modport slave (
    input  A, B, C, cfg_we, cfg_data, cfg_bit_we, cfg_addr, cfg_bit,
    output F, cfg_table
  );
endinterface
`default_nettype wire

// File: rtl/lut3.sv
`default_nettype none
// ============================================================================
// lut3 : runtime-programmable 3-input look-up table, F = table[{A,B,C}]
// Rev 1.0 : initial release
// ============================================================================
module lut3 #(
  parameter logic [7:0] INIT = 8'hE8
) (
  input  logic   clk,
  input  logic   rst,
  lut3_if.slave  bus
);

  logic [7:0] lut_table;

  // Whole-table write wins over a same-edge single-entry write.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_table <= INIT;
    end else if (bus.cfg_we) begin
      lut_table <= bus.cfg_data;
    end else if (bus.cfg_bit_we) begin
      lut_table[bus.cfg_addr] <= bus.cfg_bit;
    end
  end

  assign bus.F         = lut_table[{bus.A, bus.B, bus.C}];
  assign bus.cfg_table = lut_table;

endmodule
`default_nettype wire

// File: tb/tb_lut3.sv
`default_nettype none
// ============================================================================
// tb_lut3 : directed self-checking bench for lut3
// Rev 1.0 : initial release
// ============================================================================
module tb_lut3;

  logic clk;
  logic rst;
  logic clk_en;
  int   n_checks;
  int   n_errors;

  lut3_if bus ();

  lut3 #(.INIT(8'hE8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Gated clock so the combinational read path can be exercised with no edges.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_abc(input logic [2:0] idx);
    {bus.A, bus.B, bus.C} = idx;
  endtask

  task automatic sweep(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      set_abc(3'(i));
      #20;
      check($sformatf("%s_F%0d", tag, i), {7'd0, bus.F}, {7'd0, exp[i]});
    end
  endtask

  // Apply currently driven controls for exactly one rising edge, then release.
  task automatic one_edge();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_bit_we = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    clk            = 1'b0;
    clk_en         = 1'b1;
    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_data   = 8'h00;
    bus.cfg_bit_we = 1'b0;
    bus.cfg_addr   = 3'd0;
    bus.cfg_bit    = 1'b0;
    set_abc(3'd0);

    // 1: reset loads majority table
    one_edge();
    check("rst_table", bus.cfg_table, 8'hE8);
    sweep("rst", 8'hE8);

    // hold: idle edges leave the table alone
    repeat (3) one_edge();
    check("hold_table", bus.cfg_table, 8'hE8);

    // 2: whole-table write, odd parity
    bus.cfg_data = 8'h96;
    bus.cfg_we   = 1'b1;
    #1;
    check("we_before_edge", bus.cfg_table, 8'hE8);
    one_edge();
    check("we_table", bus.cfg_table, 8'h96);
    sweep("par", 8'h96);

    // 3: single-entry set of bit 0
    bus.cfg_addr   = 3'd0;
    bus.cfg_bit    = 1'b1;
    bus.cfg_bit_we = 1'b1;
    one_edge();
    check("bit0_table", bus.cfg_table, 8'h97);
    sweep("bit0", 8'h97);

    // single-entry clear of bit 7
    bus.cfg_addr   = 3'd7;
    bus.cfg_bit    = 1'b0;
    bus.cfg_bit_we = 1'b1;
    one_edge();
    check("bit7_clr_table", bus.cfg_table, 8'h17);

    // single-entry set of bit 5 (mid index)
    bus.cfg_addr   = 3'd5;
    bus.cfg_bit    = 1'b1;
    bus.cfg_bit_we = 1'b1;
    one_edge();
    check("bit5_set_table", bus.cfg_table, 8'h37);

    // 4: cfg_we beats cfg_bit_we on the same edge
    bus.cfg_data   = 8'h0F;
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 3'd7;
    bus.cfg_bit    = 1'b1;
    bus.cfg_bit_we = 1'b1;
    one_edge();
    check("prio_table", bus.cfg_table, 8'h0F);
    set_abc(3'd7);
    #20;
    check("prio_F7", {7'd0, bus.F}, 8'h00);

    // 5: reset beats cfg_we
    bus.cfg_data = 8'hFF;
    bus.cfg_we   = 1'b1;
    rst          = 1'b1;
    one_edge();
    check("rstprio_table", bus.cfg_table, 8'hE8);
    sweep("rstprio", 8'hE8);

    // 6: stop the clock low and toggle the select inputs
    @(negedge clk);
    clk_en = 1'b0;
    #7;
    set_abc(3'b011);
    #1;
    check("noclk_F3", {7'd0, bus.F}, 8'h01);
    set_abc(3'b100);
    #1;
    check("noclk_F4", {7'd0, bus.F}, 8'h00);
    set_abc(3'b011);
    #1;
    check("noclk_F3b", {7'd0, bus.F}, 8'h01);
    set_abc(3'b001);
    #1;
    check("noclk_F1", {7'd0, bus.F}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
